// File: rtl/lift_pkg.sv
// lift_pkg
//   Shared definitions for the lift blocks: door-state encoding, default
//   tick counts (also used by the display and lift state-machine blocks),
//   and the bundled door input-event struct.
package lift_pkg;

    // Door state encoding. The display block decodes these directly.
    typedef enum logic [1:0] {
        DOOR_CLOSED  = 2'b00,
        DOOR_OPENING = 2'b01,
        DOOR_OPEN    = 2'b10,
        DOOR_CLOSING = 2'b11
    } door_state_e;

    // Default phase lengths, in slowref strobes.
    localparam int DEF_OPEN_TICKS  = 2;
    localparam int DEF_DWELL_TICKS = 8;
    localparam int DEF_CLOSE_TICKS = 2;
    localparam int DEF_MAX_REOPEN  = 3;
    localparam int DEF_CNT_W       = 6;

    // Door request bundle as seen by the door FSM in one clk.
    typedef struct packed {
        logic arrive;
        logic moving;
        logic open_btn;
        logic close_btn;
        logic obstruct;
    } door_ev_t;

endpackage

// File: rtl/lift_door_tick_cnt.sv
// tick_cnt
//   Loadable down-counter advanced by the slowref strobe. Load wins over a
//   coinciding strobe, so a strobe in a phase's entry cycle never counts.
//   The counter saturates at zero instead of wrapping.
// Ports:
//   clk, resetb : clock, synchronous active-low reset
//   load        : load load_val this clk
//   load_val    : value to load
//   tick        : slowref strobe, decrements when not loading
//   cnt         : current count
//   zero        : cnt == 0
module tick_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!resetb) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lift_door.sv
// lift_door
//   Car door sequencer: CLOSED -> OPENING -> OPEN (dwell) -> CLOSING -> CLOSED,
//   with open-button dwell restart, close-button early close, obstruction
//   hold/reopen, and a per-visit reopen limit that raises a sticky nudge.
// Ports:
//   clk, resetb  : 50 MHz clock, synchronous active-low reset
//   slowref      : one-clk timing strobe; all phase lengths count these
//   arrive       : one-clk pulse, car stopped at a floor
//   moving       : level, car in motion (blocks open_btn while closed)
//   open_btn     : one-clk pulse, door-open button
//   close_btn    : one-clk pulse, door-close button
//   obstruct     : level, door-edge sensor
//   door_open    : LED, door not closed
//   door_busy    : to lift FSM, door not closed
//   door_state   : CLOSED=00 OPENING=01 OPEN=10 CLOSING=11
//   door_closed  : one-clk pulse on entry to CLOSED
//   nudge        : sticky, reopen limit exceeded this visit
module lift_door
    import lift_pkg::*;
#(
    parameter int OPEN_TICKS  = DEF_OPEN_TICKS,
    parameter int DWELL_TICKS = DEF_DWELL_TICKS,
    parameter int CLOSE_TICKS = DEF_CLOSE_TICKS,
    parameter int MAX_REOPEN  = DEF_MAX_REOPEN,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       slowref,
    input  logic       arrive,
    input  logic       moving,
    input  logic       open_btn,
    input  logic       close_btn,
    input  logic       obstruct,
    output logic       door_open,
    output logic       door_busy,
    output logic [1:0] door_state,
    output logic       door_closed,
    output logic       nudge
);

    // Reopen counter only needs to reach MAX_REOPEN, where it saturates.
    localparam int RW = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);

    localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_TICKS - 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_TICKS - 1);
    localparam logic [CNT_W-1:0] CLOSE_LD = CNT_W'(CLOSE_TICKS - 1);

    door_state_e      state;
    door_state_e      nxt;
    door_ev_t         ev;
    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic [CNT_W-1:0] cnt;
    logic             zero;
    logic             expire;
    logic             reopen;
    logic [RW-1:0]    reopen_cnt;

    assign ev.arrive    = arrive;
    assign ev.moving    = moving;
    assign ev.open_btn  = open_btn;
    assign ev.close_btn = close_btn;
    assign ev.obstruct  = obstruct;

    tick_cnt #(.CNT_W(CNT_W)) u_tick (
        .clk      (clk),
        .resetb   (resetb),
        .load     (ld),
        .load_val (ld_val),
        .tick     (slowref),
        .cnt      (cnt),
        .zero     (zero)
    );

    // A phase ends on a strobe that finds the counter already at zero.
    assign expire = slowref && zero;

    // Next state and counter load. Every state entry loads the counter;
    // the only other load is the dwell restart from open_btn in OPEN.
    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        ld_val = '0;
        reopen = 1'b0;
        case (state)
            DOOR_CLOSED: begin
                // arrive opens regardless of moving; arrive+open_btn is one open
                if (ev.arrive || (ev.open_btn && !ev.moving)) begin
                    nxt    = DOOR_OPENING;
                    ld     = 1'b1;
                    ld_val = OPEN_LD;
                end
            end
            DOOR_OPENING: begin
                if (expire) begin
                    nxt    = DOOR_OPEN;
                    ld     = 1'b1;
                    ld_val = DWELL_LD;
                end
            end
            DOOR_OPEN: begin
                // Obstruction blocks every way out of OPEN. The counter keeps
                // running and parks at zero, so the first strobe after the
                // obstruction clears starts the close.
                if (!ev.obstruct) begin
                    if (ev.open_btn) begin
                        ld     = 1'b1;
                        ld_val = DWELL_LD;
                    end else if (ev.close_btn || expire) begin
                        nxt    = DOOR_CLOSING;
                        ld     = 1'b1;
                        ld_val = CLOSE_LD;
                    end
                end
            end
            DOOR_CLOSING: begin
                // Reopen outranks finishing the close in the same clk.
                if (ev.obstruct || ev.open_btn) begin
                    nxt    = DOOR_OPENING;
                    ld     = 1'b1;
                    ld_val = OPEN_LD;
                    reopen = 1'b1;
                end else if (expire) begin
                    nxt    = DOOR_CLOSED;
                    ld     = 1'b1;
                    ld_val = '0;
                end
            end
            default: begin
                nxt = DOOR_CLOSED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state       <= DOOR_CLOSED;
            reopen_cnt  <= '0;
            nudge       <= 1'b0;
            door_closed <= 1'b0;
            door_open   <= 1'b0;
            door_busy   <= 1'b0;
        end else begin
            state       <= nxt;
            door_closed <= (state != DOOR_CLOSED) && (nxt == DOOR_CLOSED);
            door_open   <= (nxt != DOOR_CLOSED);
            door_busy   <= (nxt != DOOR_CLOSED);
            if ((state != DOOR_CLOSED) && (nxt == DOOR_CLOSED)) begin
                // New visit starts clean.
                reopen_cnt <= '0;
                nudge      <= 1'b0;
            end else if (reopen) begin
                // The reopen itself always happens; only the indicator changes.
                if (reopen_cnt == RW'(MAX_REOPEN)) begin
                    nudge <= 1'b1;
                end else begin
                    reopen_cnt <= reopen_cnt + RW'(1);
                end
            end
        end
    end

    assign door_state = state;

endmodule

// File: tb/tb_lift_door.sv
// tb_lift_door
//   Scoreboard bench for lift_door: each driven cycle may push the outputs
//   the door must show after the next edge; the sampler pops and compares.
module tb_lift_door;

    localparam logic [1:0] S_CL = 2'b00;
    localparam logic [1:0] S_OG = 2'b01;
    localparam logic [1:0] S_OP = 2'b10;
    localparam logic [1:0] S_CG = 2'b11;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       slowref = 1'b0;
    logic       arrive = 1'b0;
    logic       moving = 1'b0;
    logic       open_btn = 1'b0;
    logic       close_btn = 1'b0;
    logic       obstruct = 1'b0;
    logic       door_open;
    logic       door_busy;
    logic [1:0] door_state;
    logic       door_closed;
    logic       nudge;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       cl;
        logic       nd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errs = 0;
    int   closed_seen = 0;
    int   closed_exp = 0;
    logic exp_nudge = 1'b0;

    always #10 clk = ~clk;

    lift_door dut (
        .clk         (clk),
        .resetb      (resetb),
        .slowref     (slowref),
        .arrive      (arrive),
        .moving      (moving),
        .open_btn    (open_btn),
        .close_btn   (close_btn),
        .obstruct    (obstruct),
        .door_open   (door_open),
        .door_busy   (door_busy),
        .door_state  (door_state),
        .door_closed (door_closed),
        .nudge       (nudge)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void want(input string tag, input logic [1:0] st, input logic cl);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.cl  = cl;
        e.nd  = exp_nudge;
        exp_q.push_back(e);
        if (cl) closed_exp++;
    endfunction

    // One clk: advance past the edge, then compare any pending expectation.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (door_closed === 1'b1) closed_seen++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.tag, " state"},  int'(door_state),  int'(e.st));
            chk({e.tag, " open"},   int'(door_open),   int'(e.st != S_CL));
            chk({e.tag, " busy"},   int'(door_busy),   int'(e.st != S_CL));
            chk({e.tag, " closed"}, int'(door_closed), int'(e.cl));
            chk({e.tag, " nudge"},  int'(nudge),       int'(e.nd));
        end
    endtask

    // n strobes, each followed by a quiet clk; state is mid until the
    // last strobe, which must land in fin.
    task automatic strobes(input string tag, input int n, input logic [1:0] mid,
                           input logic [1:0] fin);
        logic       last;
        logic [1:0] s;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            s    = last ? fin : mid;
            if (last && fin == S_CL && mid != S_CL) exp_nudge = 1'b0;
            slowref = 1'b1;
            want(tag, s, last && fin == S_CL && mid != S_CL);
            step();
            slowref = 1'b0;
            want(tag, s, 1'b0);
            step();
        end
    endtask

    task automatic reopen_by_obstruct(input string tag);
        obstruct = 1'b1;
        want(tag, S_OG, 1'b0);
        step();
        obstruct = 1'b0;
    endtask

    task automatic open_then_close_btn(input string tag);
        strobes({tag, " opening"}, 2, S_OG, S_OP);
        close_btn = 1'b1;
        want({tag, " close_btn"}, S_CG, 1'b0);
        step();
        close_btn = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        resetb = 1'b0;
        step();
        want("reset", S_CL, 1'b0);
        step();
        resetb = 1'b1;
        want("idle", S_CL, 1'b0);
        step();

        // Full cycle with no events: 2 + 8 + 2 strobes
        arrive = 1'b1;
        want("arrive", S_OG, 1'b0);
        step();
        arrive = 1'b0;
        strobes("full opening", 2, S_OG, S_OP);
        strobes("full dwell", 8, S_OP, S_CG);
        strobes("full closing", 2, S_CG, S_CL);
        chk("full closed_pulses", closed_seen, 1);

        // open_btn on strobe 5 of dwell restarts dwell
        arrive = 1'b1;
        want("restart arrive", S_OG, 1'b0);
        step();
        arrive = 1'b0;
        strobes("restart opening", 2, S_OG, S_OP);
        strobes("restart dwell4", 4, S_OP, S_OP);
        slowref  = 1'b1;
        open_btn = 1'b1;
        want("restart press", S_OP, 1'b0);
        step();
        slowref  = 1'b0;
        open_btn = 1'b0;
        strobes("restart dwell8", 8, S_OP, S_CG);
        strobes("restart closing", 2, S_CG, S_CL);

        // close_btn blocked by obstruction; obstruction holds OPEN past expiry
        arrive = 1'b1;
        want("obs arrive", S_OG, 1'b0);
        step();
        arrive = 1'b0;
        strobes("obs opening", 2, S_OG, S_OP);
        close_btn = 1'b1;
        obstruct  = 1'b1;
        want("obs close_btn", S_OP, 1'b0);
        step();
        close_btn = 1'b0;
        strobes("obs hold", 10, S_OP, S_OP);
        obstruct = 1'b0;
        want("obs cleared", S_OP, 1'b0);
        step();
        strobes("obs reeval", 1, S_OP, S_CG);
        strobes("obs closing", 2, S_CG, S_CL);
        arrive = 1'b1;
        want("cbtn arrive", S_OG, 1'b0);
        step();
        arrive = 1'b0;
        open_then_close_btn("cbtn");
        strobes("cbtn closing", 2, S_CG, S_CL);

        // Reopen limit: three reopens quiet, fourth sets nudge
        arrive = 1'b1;
        want("reo arrive", S_OG, 1'b0);
        step();
        arrive = 1'b0;
        open_then_close_btn("reo0");
        reopen_by_obstruct("reo1");
        open_then_close_btn("reo1");
        open_btn = 1'b1;
        want("reo2 open_btn", S_OG, 1'b0);
        step();
        open_btn = 1'b0;
        open_then_close_btn("reo2");
        reopen_by_obstruct("reo3");
        open_then_close_btn("reo3");
        exp_nudge = 1'b1;
        reopen_by_obstruct("reo4");
        open_then_close_btn("reo4");
        strobes("reo closing", 2, S_CG, S_CL);

        // Closed: open_btn while moving and close_btn ignored
        moving   = 1'b1;
        open_btn = 1'b1;
        want("moving open_btn", S_CL, 1'b0);
        step();
        moving    = 1'b0;
        open_btn  = 1'b0;
        close_btn = 1'b1;
        want("closed close_btn", S_CL, 1'b0);
        step();
        close_btn = 1'b0;
        open_btn  = 1'b1;
        want("still open_btn", S_OG, 1'b0);
        step();
        open_btn = 1'b0;
        strobes("btn opening", 2, S_OG, S_OP);
        strobes("btn dwell3", 3, S_OP, S_OP);
        arrive = 1'b1;
        want("arrive in open", S_OP, 1'b0);
        step();
        arrive = 1'b0;
        strobes("btn dwell5", 5, S_OP, S_CG);
        strobes("btn closing", 2, S_CG, S_CL);

        // arrive while moving, with a strobe in the entry cycle
        moving  = 1'b1;
        arrive  = 1'b1;
        slowref = 1'b1;
        want("entry strobe", S_OG, 1'b0);
        step();
        moving  = 1'b0;
        arrive  = 1'b0;
        slowref = 1'b0;
        strobes("entry opening", 2, S_OG, S_OP);

        // Reset while OPEN: closed, no door_closed pulse
        resetb = 1'b0;
        want("midreset", S_CL, 1'b0);
        step();
        resetb = 1'b1;
        want("post reset", S_CL, 1'b0);
        step();

        chk("closed_pulses", closed_seen, closed_exp);
        chk("queue drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
